// File: rtl/inta_cycle_sequencer.sv
// CPU-side interrupt acknowledge sequencer: answers PIC INT with an INTA_n pulse
// train (2 pulses in 8086 mode, 3 in 8080/85 mode) and captures the bus bytes.
module inta_cycle_sequencer #(
    parameter int PULSE_LOW = 2,
    parameter int PULSE_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        int_enable,
    input  logic        mode_8086,
    input  logic [7:0]  data_in,
    output logic        INTA,
    output logic        busy,
    output logic        vector_valid,
    output logic [7:0]  vector,
    output logic [15:0] call_addr,
    output logic        opcode_err
);

    typedef enum logic [2:0] {IDLE, LOW1, GAP1, LOW2, GAP2, LOW3, HOLD} state_t;

    localparam logic [7:0] LOW_LD   = 8'(PULSE_LOW - 1);
    localparam logic [7:0] GAP_LD   = 8'(PULSE_GAP - 1);
    localparam logic [7:0] CALL_OPC = 8'hCD;

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic        mode_q, mode_d;
    logic [7:0]  lo_byte, lo_byte_d;
    logic        inta_d, busy_d, vv_d, err_d;
    logic [7:0]  vector_d;
    logic [15:0] call_addr_d;
    logic        last;

    assign last = (cnt == 8'd0);

    always_comb begin
        state_d     = state;
        cnt_d       = last ? 8'd0 : cnt - 8'd1;
        mode_d      = mode_q;
        lo_byte_d   = lo_byte;
        inta_d      = INTA;
        busy_d      = busy;
        vv_d        = 1'b0;
        err_d       = opcode_err;
        vector_d    = vector;
        call_addr_d = call_addr;

        case (state)
            IDLE: begin
                if (INT && int_enable) begin
                    state_d = LOW1;
                    cnt_d   = LOW_LD;
                    inta_d  = 1'b0;
                    busy_d  = 1'b1;
                    mode_d  = mode_8086;
                    err_d   = 1'b0;
                end
            end
            LOW1: begin
                if (last) begin
                    // 8086 pulse-1 byte is meaningless; only 8080 checks for CALL
                    if (!mode_q && data_in != CALL_OPC)
                        err_d = 1'b1;
                    state_d = GAP1;
                    cnt_d   = GAP_LD;
                    inta_d  = 1'b1;
                end
            end
            GAP1: begin
                if (last) begin
                    state_d = LOW2;
                    cnt_d   = LOW_LD;
                    inta_d  = 1'b0;
                end
            end
            LOW2: begin
                if (last) begin
                    cnt_d  = GAP_LD;
                    inta_d = 1'b1;
                    if (mode_q) begin
                        vector_d = data_in;
                        vv_d     = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        lo_byte_d = data_in;
                        state_d   = GAP2;
                    end
                end
            end
            GAP2: begin
                if (last) begin
                    state_d = LOW3;
                    cnt_d   = LOW_LD;
                    inta_d  = 1'b0;
                end
            end
            LOW3: begin
                if (last) begin
                    call_addr_d = {data_in, lo_byte};
                    vv_d        = 1'b1;
                    cnt_d       = GAP_LD;
                    inta_d      = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                inta_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            mode_q       <= 1'b0;
            lo_byte      <= 8'h00;
            INTA         <= 1'b1;
            busy         <= 1'b0;
            vector_valid <= 1'b0;
            vector       <= 8'h00;
            call_addr    <= 16'h0000;
            opcode_err   <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            mode_q       <= mode_d;
            lo_byte      <= lo_byte_d;
            INTA         <= inta_d;
            busy         <= busy_d;
            vector_valid <= vv_d;
            vector       <= vector_d;
            call_addr    <= call_addr_d;
            opcode_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Bench for inta_cycle_sequencer: a PIC bus model feeds bytes per pulse, a scoreboard
// holds expected capture results, and each scenario task checks pulse timing inline.
module tb_inta_cycle_sequencer;

    localparam int PL = 2;
    localparam int PG = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        int_enable = 1'b0;
    logic        mode_8086 = 1'b0;
    logic [7:0]  data_in = 8'hEE;
    logic        INTA;
    logic        busy;
    logic        vector_valid;
    logic [7:0]  vector;
    logic [15:0] call_addr;
    logic        opcode_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  vec;
        logic [15:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  exp_vec  = 8'h00;
    logic [15:0] exp_addr = 16'h0000;
    logic [7:0]  bus_bytes [3];
    int          pidx = 0;
    logic        prev_inta = 1'b1;

    inta_cycle_sequencer #(.PULSE_LOW(PL), .PULSE_GAP(PG)) dut (
        .clk(clk), .rst(rst), .INT(INT), .int_enable(int_enable),
        .mode_8086(mode_8086), .data_in(data_in), .INTA(INTA), .busy(busy),
        .vector_valid(vector_valid), .vector(vector), .call_addr(call_addr),
        .opcode_err(opcode_err)
    );

    always #5 clk = ~clk;

    // PIC data-bus model: drive the byte belonging to the current low pulse
    always @(negedge clk) begin
        if (!busy) begin
            pidx = 0;
        end else if (INTA == 1'b0 && prev_inta == 1'b1) begin
            pidx = pidx + 1;
        end
        prev_inta = INTA;
        if (INTA == 1'b0 && pidx >= 1 && pidx <= 3)
            data_in = bus_bytes[pidx-1];
        else
            data_in = 8'hEE;
    end

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!rst && vector_valid === 1'b1) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_strobe: vector_valid high with no expected result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (vector !== e.vec || call_addr !== e.addr || opcode_err !== e.err) begin
                    errors = errors + 1;
                    $display("FAIL sb_capture: got vec=%h addr=%h err=%b, want vec=%h addr=%h err=%b",
                             vector, call_addr, opcode_err, e.vec, e.addr, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    // Runs one full acknowledge sequence starting at the next edge, checking every cycle.
    task automatic run_seq(input bit m, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit keep_int);
        int   n, busy_len, vv_k;
        logic exp_err, exp_inta, exp_busy, exp_vv, exp_err_now;
        n        = m ? 2 : 3;
        busy_len = n * (PL + PG);
        vv_k     = n * PL + (n - 1) * PG;
        bus_bytes[0] = b0;
        bus_bytes[1] = b1;
        bus_bytes[2] = b2;
        mode_8086  = m;
        INT        = 1'b1;
        int_enable = 1'b1;
        exp_err = !m && (b0 != 8'hCD);
        if (m) exp_vec = b1;
        else   exp_addr = {b2, b1};
        sb.push_back('{vec: exp_vec, addr: exp_addr, err: exp_err});
        @(posedge clk);
        for (int k = 0; k <= busy_len; k++) begin
            @(negedge clk);
            exp_inta = 1'b1;
            for (int p = 0; p < n; p++)
                if (k >= p * (PL + PG) && k < p * (PL + PG) + PL) exp_inta = 1'b0;
            exp_busy    = (k < busy_len);
            exp_vv      = (k == vv_k);
            exp_err_now = exp_err && (k >= PL);
            checks = checks + 4;
            if (INTA !== exp_inta) begin
                errors = errors + 1;
                $display("FAIL seq_inta k=%0d: got %b want %b", k, INTA, exp_inta);
            end
            if (busy !== exp_busy) begin
                errors = errors + 1;
                $display("FAIL seq_busy k=%0d: got %b want %b", k, busy, exp_busy);
            end
            if (vector_valid !== exp_vv) begin
                errors = errors + 1;
                $display("FAIL seq_vector_valid k=%0d: got %b want %b", k, vector_valid, exp_vv);
            end
            if (opcode_err !== exp_err_now) begin
                errors = errors + 1;
                $display("FAIL seq_opcode_err k=%0d: got %b want %b", k, opcode_err, exp_err_now);
            end
            if (k == 0 && !keep_int) INT = 1'b0;
            if (k == 1 && keep_int)  mode_8086 = !m;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (INTA !== 1'b1 || busy !== 1'b0 || vector_valid !== 1'b0 ||
            vector !== 8'h00 || call_addr !== 16'h0000 || opcode_err !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_values: got inta=%b busy=%b vv=%b vec=%h addr=%h err=%b, want 1 0 0 00 0000 0",
                     INTA, busy, vector_valid, vector, call_addr, opcode_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (INTA !== 1'b1 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_release: got inta=%b busy=%b want 1 0", INTA, busy);
        end
    endtask

    task automatic test_8086();
        run_seq(1'b1, 8'hFF, 8'h48, 8'h00, 1'b0);
        checks = checks + 1;
        if (vector !== 8'h48) begin
            errors = errors + 1;
            $display("FAIL v8086_vector: got %h want 48", vector);
        end
    endtask

    task automatic test_8080();
        run_seq(1'b0, 8'hCD, 8'h34, 8'h12, 1'b0);
        checks = checks + 2;
        if (call_addr !== 16'h1234) begin
            errors = errors + 1;
            $display("FAIL v8080_call_addr: got %h want 1234", call_addr);
        end
        if (vector !== 8'h48) begin
            errors = errors + 1;
            $display("FAIL v8080_vector_kept: got %h want 48", vector);
        end
    endtask

    task automatic test_opcode_err();
        run_seq(1'b0, 8'hC3, 8'h78, 8'h56, 1'b0);
        checks = checks + 1;
        if (opcode_err !== 1'b1 || call_addr !== 16'h5678) begin
            errors = errors + 1;
            $display("FAIL opcode_err_sticky: got err=%b addr=%h want 1 5678", opcode_err, call_addr);
        end
        // next start clears the flag (checked at k=0 inside run_seq)
        run_seq(1'b1, 8'h00, 8'h21, 8'h00, 1'b0);
    endtask

    task automatic test_int_disabled();
        INT        = 1'b1;
        int_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks = checks + 1;
            if (INTA !== 1'b1 || busy !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL int_disabled cyc=%0d: got inta=%b busy=%b want 1 0", i, INTA, busy);
            end
        end
        run_seq(1'b0, 8'hCD, 8'hBC, 8'h9A, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus_bytes[0] = 8'h00;
        bus_bytes[1] = 8'h77;
        bus_bytes[2] = 8'h00;
        mode_8086  = 1'b1;
        INT        = 1'b1;
        int_enable = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) INT = 1'b0;
        end
        checks = checks + 1;
        if (INTA !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rst_mid_in_low2: got inta=%b want 0", INTA);
        end
        rst = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (INTA !== 1'b1 || busy !== 1'b0 || vector !== 8'h00 || call_addr !== 16'h0000) begin
            errors = errors + 1;
            $display("FAIL rst_mid_after: got inta=%b busy=%b vec=%h addr=%h want 1 0 00 0000",
                     INTA, busy, vector, call_addr);
        end
        rst = 1'b0;
        exp_vec  = 8'h00;
        exp_addr = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks = checks + 1;
            if (INTA !== 1'b1 || busy !== 1'b0 || vector !== 8'h00) begin
                errors = errors + 1;
                $display("FAIL rst_mid_quiet cyc=%0d: got inta=%b busy=%b vec=%h want 1 0 00",
                         i, INTA, busy, vector);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_seq(1'b1, 8'h00, 8'hA5, 8'h00, 1'b1);
        run_seq(1'b0, 8'hCD, 8'h0F, 8'hF0, 1'b1);
        run_seq(1'b1, 8'h00, 8'h5A, 8'h00, 1'b0);
        checks = checks + 1;
        if (vector !== 8'h5A || call_addr !== 16'hF00F) begin
            errors = errors + 1;
            $display("FAIL b2b_final: got vec=%h addr=%h want 5a f00f", vector, call_addr);
        end
    endtask

    initial begin
        test_reset();
        test_8086();
        test_8080();
        test_opcode_err();
        test_int_disabled();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain: %0d expected results never produced, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inta_cycle_sequencer.md
Name: inta_cycle_sequencer

Overview:
CPU-side responder to the PIC interrupt output. It samples INT, drives the active-low INTA pulse train, and captures the bytes the PIC places on the data bus. In 8086 mode it issues 2 pulses and captures the vector byte. In 8080/85 mode it issues 3 pulses and captures the CALL opcode plus a 16-bit address. It serves as the bench-side and system-side partner of the PIC acknowledge logic.

Parameters:
PULSE_LOW, 2, clock cycles INTA_n is held low per pulse (legal 1..255)
PULSE_GAP, 2, clock cycles INTA_n is high between pulses and in post-sequence holdoff (legal 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
INT  input  1  interrupt request from PIC, active-high
int_enable  input  1  CPU interrupt-enable flag; sequence starts only when high
mode_8086  input  1  1 = 8086 (2 pulses), 0 = 8080/85 (3 pulses); latched at sequence start
data_in  input  8  PIC data bus, sampled at the end of each low phase
INTA  output  1  interrupt acknowledge to PIC, active low
busy  output  1  high from sequence start until return to IDLE
vector_valid  output  1  one-cycle strobe: captured data valid
vector  output  8  8086 vector byte (captured on pulse 2)
call_addr  output  16  8080 address {pulse3 byte, pulse2 byte}
opcode_err  output  1  8080 mode: pulse-1 byte was not 8'hCD; sticky until next sequence start

Behaviour:
- All outputs are registered. Reset values: INTA=1, busy=0, vector_valid=0, vector=8'h00, call_addr=16'h0000, opcode_err=0. State=IDLE, counter=0.
- A reset at any point, including mid-pulse, forces INTA high after that edge, discards any partial capture, and returns to IDLE.
- States: IDLE, LOW1, GAP1, LOW2, GAP2, LOW3, HOLD. There is one shared 8-bit down-counter.
- IDLE: at edge E with INT=1 and int_enable=1:
  - go to LOW1;
  - INTA=0 and busy=1 after E;
  - latch mode_8086;
  - clear opcode_err.
- LOWn: INTA low for exactly PULSE_LOW cycles. At the final edge (INTA rises after it), sample data_in and go to GAPn or HOLD.
- GAPn: INTA high for exactly PULSE_GAP cycles, then go to the next LOWn.
- 8086 timing:
  - pulse 1 spans E .. E+PULSE_LOW; its data byte is ignored;
  - pulse 2 falls after E+PULSE_LOW+PULSE_GAP;
  - pulse 2 rises after E+2*PULSE_LOW+PULSE_GAP, and vector is loaded at that edge;
  - vector_valid is high for the following single cycle;
  - go to HOLD.
- 8080 mode:
  - pulse-1 byte is compared with 8'hCD; on mismatch opcode_err=1 and the sequence continues regardless;
  - pulse-2 byte goes to call_addr[7:0];
  - pulse-3 byte goes to call_addr[15:8];
  - call_addr and vector_valid update after the pulse-3 rise at E+3*PULSE_LOW+2*PULSE_GAP;
  - vector is unchanged in 8080 mode.
- HOLD: INTA high for PULSE_GAP cycles, then IDLE with busy=0. The earliest next sampling edge is one edge after IDLE is reached.
- INT, int_enable and mode_8086 are ignored while busy. Dropping INT mid-sequence does not abort the sequence; the PIC is expected to drop INT during pulse 1.
- INT still high on return to IDLE (with int_enable=1) starts a new sequence.
- vector and call_addr hold their values until overwritten by a later sequence or by reset.

Test Plan:
- Reset, then mode_8086=1. INT=1 and int_enable=1 sampled at edge 10, with data_in=8'h48 during pulse 2 → INTA low after edges 10-11 and 14-15. vector=8'h48 and vector_valid high for the cycle after edge 16. busy falls after edge 18.
- mode_8086=0, bus bytes CD/34/12 → three low pulses. call_addr=16'h1234, opcode_err=0, vector_valid strobe after the pulse-3 rise.
- mode_8086=0, first byte 8'hC3 → opcode_err=1, all three pulses still issued, call_addr still captured. opcode_err clears at the next sequence start.
- INT=1 with int_enable=0 for 20 cycles → INTA stays high and busy=0. Raising int_enable starts the sequence on the next edge.
- rst asserted during LOW2 → INTA=1 and busy=0 after that edge; vector keeps its reset value 0 and no vector_valid strobe occurs.
- INT held high continuously → back-to-back sequences separated by PULSE_GAP holdoff plus one IDLE cycle. Toggling mode_8086 mid-sequence has no effect until the next start.
